// File: rtl/rr_arb_pkg.sv
// Shared definitions for the eight-client round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [0:0] {IDLE, GRANT} arb_state_e;

    // First set request bit searching ptr, ptr+1, ... ptr+7 with 3-bit wrap.
    // Returns ptr when req is empty; callers only use the result when req != 0.
    function automatic logic [IDX_W-1:0] next_winner(input logic [NUM_REQ-1:0] req,
                                                     input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] win;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module decoder3to8 (
    input  logic [2:0] A,
    input  logic       E,
    output logic [7:0] Y
);

    // One-hot expansion of A, gated by E.
    always_comb begin
        Y = '0;
        if (E) begin
            Y[A] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter. The winner index and valid flag are
// registered and expanded to a one-hot grant by decoder3to8, so the grant can
// never have more than one bit set.
// Optional feature macro: RR_ARB_HOLD_TIMEOUT_EN (force rotation after MAX_HOLD
// consecutive grant cycles when another client is waiting).
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;

    logic [NUM_REQ-1:0] cur_onehot;
    logic [NUM_REQ-1:0] others;
    logic [IDX_W-1:0]   ptr_after;
    logic               release_now;

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    localparam int unsigned      HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout;
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    // State register: FSM, winner index, valid flag, priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    // Next-state: arbitration from IDLE, hold/release/rotate while granting.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        valid_d     = valid_q;
        cur_onehot  = '0;
        cur_onehot[idx_q] = 1'b1;
        // Competitors of the current holder; the holder ranks last from ptr_after.
        others      = req & ~cur_onehot;
        ptr_after   = idx_q + IDX_W'(1);
        release_now = !req[idx_q];
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        hold_d      = hold_q;
        timeout     = (hold_q == HOLD_LAST) && (others != '0);
        release_now = release_now || timeout;
`endif

        if (!en) begin
            state_d = IDLE;
            valid_d = 1'b0;
            if (state_q == GRANT) begin
                ptr_d = ptr_after;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req != '0) begin
                        state_d = GRANT;
                        idx_d   = next_winner(req, ptr_q);
                        valid_d = 1'b1;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                        hold_d  = '0;
`endif
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr_d = ptr_after;
                        if (others != '0) begin
                            // Back-to-back handover, no idle bubble.
                            idx_d   = next_winner(others, ptr_after);
                            valid_d = 1'b1;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                            hold_d  = '0;
`endif
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end
                    end else begin
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                        // Saturate when nobody else waits.
                        if (hold_q != HOLD_LAST) begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        gnt_idx   = idx_q;
        gnt_valid = valid_q;
    end

    decoder3to8 u_dec (
        .A (idx_q),
        .E (valid_q),
        .Y (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8 with hand-computed expectations.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_checks;
    int n_fail;

    rr_arbiter8 #(
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input int idx);
        logic [7:0] oh;
        oh = 8'h00;
        oh[idx] = 1'b1;
        check({tag, ".gnt"}, 32'(gnt), 32'(oh));
        check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, ".valid"}, 32'(gnt_valid), 32'd1);
    endtask

    task automatic expect_none(input string tag);
        check({tag, ".gnt"}, 32'(gnt), 32'd0);
        check({tag, ".valid"}, 32'(gnt_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        en       = 1'b1;
        req      = 8'h00;

        // Reset state
        step();
        check("rst.gnt", 32'(gnt), 32'd0);
        check("rst.idx", 32'(gnt_idx), 32'd0);
        check("rst.valid", 32'(gnt_valid), 32'd0);
        rst = 1'b0;

        // No requests for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            expect_none("idle");
        end

        // Basic rotation: 0 -> 2 -> 7
        req = 8'b1000_0101;
        step();
        expect_grant("basic0", 0);
        step();
        expect_grant("basic0hold", 0);
        req = 8'b1000_0100;
        step();
        expect_grant("basic2", 2);
        req = 8'b1000_0000;
        step();
        expect_grant("basic7", 7);
        req = 8'h00;
        step();
        expect_none("basic_end");   // ptr now 0

        // Pointer wrap: grant 6, release -> ptr 7 -> 7 wins, then 0 without bubble
        req = 8'h40;
        step();
        expect_grant("wrap6", 6);
        req = 8'b1000_0001;
        step();
        expect_grant("wrap7", 7);
        req = 8'b0000_0001;
        step();
        expect_grant("wrap0", 0);
        req = 8'h00;
        step();
        expect_none("wrap_end");    // ptr now 1

        // Asynchronous reset mid-grant clears outputs before any clock edge
        req = 8'h10;
        step();
        expect_grant("pre_rst4", 4);
        #2;
        rst = 1'b1;
        #1;
        expect_none("async_rst");
        step();
        rst = 1'b0;
        req = 8'h00;
        step();
        expect_none("post_rst");    // ptr back to 0

        // All eight requesting, each releasing after 3 grant cycles: 0..7,0
        req = 8'hFF;
        step();
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 3; c++) begin
                expect_grant("all8", k % 8);
                check("all8.onehot", 32'($onehot(gnt)), 32'd1);
                if (c < 2) step();
            end
            if (k < 8) begin
                req[k % 8] = 1'b0;
                step();
                req[k % 8] = 1'b1;
            end
        end

        // Enable drop during grant to 3
        req = 8'h08;            // releases 0 (ptr 1), 3 wins
        step();
        expect_grant("en3", 3);
        en = 1'b0;
        step();
        expect_none("en_off");  // ptr 4
        req = 8'hFF;
        step();
        expect_none("en_off_ff0");
        step();
        expect_none("en_off_ff1");
        en = 1'b1;
        step();
        expect_grant("en_on4", 4);

        // Two persistent requesters from ptr 0
        req = 8'h00;
        do_reset();
        req = 8'h22;
        step();
        for (int c = 0; c < 16; c++) begin
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            expect_grant("timeout_alt", ((c / 4) % 2 == 0) ? 1 : 5);
`else
            expect_grant("hold_forever", 1);
`endif
            step();
        end

        // Lone requester holds indefinitely in every build
        req = 8'h00;
        do_reset();
        req = 8'h02;
        step();
        for (int c = 0; c < 12; c++) begin
            expect_grant("lone_hold", 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
